// File: rtl/pipe_ctrl_chain_pkg.sv
// Shared control-word layout for the ID->EX/MEM/WB control pipeline:
// field positions, the bubble word and the default per-stage field masks.
package pipe_ctrl_chain_pkg;

  localparam int CTRL_W = 14;

  // {jmpl,RW,ALU_op3[3:0],SE,load,RF_en,size[1:0],modCC,call,DM_en}
  localparam int BIT_JMPL        = 13;
  localparam int BIT_RW          = 12;
  localparam int BIT_ALU_OP3_LSB = 8;
  localparam int ALU_OP3_W       = 4;
  localparam int BIT_SE          = 7;
  localparam int BIT_LOAD        = 6;
  localparam int BIT_RF_EN       = 5;
  localparam int BIT_SIZE_LSB    = 3;
  localparam int SIZE_W          = 2;
  localparam int BIT_MODCC       = 2;
  localparam int BIT_CALL        = 1;
  localparam int BIT_DM_EN       = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

  // All-zero bubble cannot write RF, memory or CC.
  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic ctrl_t field_mask(input int lsb, input int w);
    ctrl_t m;
    m = '0;
    for (int i = 0; i < w; i++) m[lsb+i] = 1'b1;
    return m;
  endfunction

  localparam ctrl_t MASK_EX  = '1;
  localparam ctrl_t MASK_MEM = ~(field_mask(BIT_ALU_OP3_LSB, ALU_OP3_W) | field_mask(BIT_MODCC, 1));
  localparam ctrl_t MASK_WB  = field_mask(BIT_RF_EN, 1);

  localparam logic [3*CTRL_W-1:0] DEFAULT_STAGE_MASK = {MASK_WB, MASK_MEM, MASK_EX};

endpackage

// File: rtl/pipe_ctrl_chain_stage_reg.sv
// One pipeline stage: masked control word plus valid bit, with load enable and
// synchronous clear-to-bubble. An invalid stage always holds the bubble word.
module pipe_stage_reg #(
  parameter int               WIDTH = 14,
  parameter logic [WIDTH-1:0] MASK  = '1
) (
  input  logic             Clk,
  input  logic             R,
  input  logic             le,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (le) begin
      if (clr || !d_valid) begin
        q       <= '0;
        q_valid <= 1'b0;
      end else begin
        q       <= d & MASK;
        q_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// Control-word pipeline from ID into STAGES registered copies (EX, MEM, WB, ...)
// with stall/flush bubbles, EX kill, global freeze and a saturating bubble counter.
module pipe_ctrl_chain
  import pipe_ctrl_chain_pkg::*;
#(
  parameter int                      WIDTH      = CTRL_W,
  parameter int                      STAGES     = 3,
  parameter logic [STAGES*WIDTH-1:0] STAGE_MASK = '1,
  parameter int                      CNT_W      = 16
) (
  input  logic                    Clk,
  input  logic                    R,
  input  logic                    le,
  input  logic [WIDTH-1:0]        id_ctrl,
  input  logic                    id_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    ex_kill,
  output logic                    id_ready,
  output logic [STAGES*WIDTH-1:0] stage_ctrl,
  output logic [STAGES-1:0]       stage_valid,
  output logic [CNT_W-1:0]        bubble_cnt
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic             stage_v [STAGES];
  logic [CNT_W-1:0] cnt;

  assign id_ready = le & ~stall;

  // STAGES must be at least 2: stage 1 is where ex_kill applies.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] d;
    logic             dv;
    logic             clr;

    if (k == 0) begin : g_first
      assign d   = id_ctrl;
      assign dv  = id_valid;
      assign clr = stall | flush;
    end else begin : g_rest
      assign d   = stage_q[k-1];
      assign dv  = stage_v[k-1];
      assign clr = (k == 1) ? ex_kill : 1'b0;
    end

    pipe_stage_reg #(
      .WIDTH (WIDTH),
      .MASK  (STAGE_MASK[k*WIDTH +: WIDTH])
    ) u_reg (
      .Clk     (Clk),
      .R       (R),
      .le      (le),
      .clr     (clr),
      .d       (d),
      .d_valid (dv),
      .q       (stage_q[k]),
      .q_valid (stage_v[k])
    );

    assign stage_ctrl[k*WIDTH +: WIDTH] = stage_q[k];
    assign stage_valid[k]               = stage_v[k];
  end

  // Counts bubble requests, not lost instructions, so id_valid is irrelevant.
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      cnt <= '0;
    end else if (le && (stall || flush) && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bubble_cnt = cnt;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed bench for pipe_ctrl_chain: main instance with the default stage masks
// (EX all, MEM without ALU_op3/modCC, WB RF_en only) and a CNT_W=3 instance.
module tb_pipe_ctrl_chain;
  import pipe_ctrl_chain_pkg::*;

  logic        Clk = 1'b0;
  logic        R;
  logic        le;
  logic [13:0] id_ctrl;
  logic        id_valid;
  logic        stall;
  logic        flush;
  logic        ex_kill;

  logic        id_ready;
  logic [41:0] stage_ctrl;
  logic [2:0]  stage_valid;
  logic [15:0] bubble_cnt;

  logic        s_id_ready;
  logic [41:0] s_stage_ctrl;
  logic [2:0]  s_stage_valid;
  logic [2:0]  s_bubble_cnt;

  int total = 0;
  int bad   = 0;

  pipe_ctrl_chain #(
    .WIDTH(14), .STAGES(3), .STAGE_MASK(DEFAULT_STAGE_MASK), .CNT_W(16)
  ) dut (
    .Clk(Clk), .R(R), .le(le), .id_ctrl(id_ctrl), .id_valid(id_valid),
    .stall(stall), .flush(flush), .ex_kill(ex_kill), .id_ready(id_ready),
    .stage_ctrl(stage_ctrl), .stage_valid(stage_valid), .bubble_cnt(bubble_cnt)
  );

  pipe_ctrl_chain #(
    .WIDTH(14), .STAGES(3), .CNT_W(3)
  ) dut_small (
    .Clk(Clk), .R(R), .le(le), .id_ctrl(id_ctrl), .id_valid(id_valid),
    .stall(stall), .flush(flush), .ex_kill(ex_kill), .id_ready(s_id_ready),
    .stage_ctrl(s_stage_ctrl), .stage_valid(s_stage_valid), .bubble_cnt(s_bubble_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_stages(input string tag, input logic [13:0] s0, input logic [13:0] s1,
                            input logic [13:0] s2, input logic [2:0] v);
    chk({tag, " s0"}, 64'(stage_ctrl[13:0]),  64'(s0));
    chk({tag, " s1"}, 64'(stage_ctrl[27:14]), 64'(s1));
    chk({tag, " s2"}, 64'(stage_ctrl[41:28]), 64'(s2));
    chk({tag, " v"},  64'(stage_valid),       64'(v));
  endtask

  initial begin
    R = 1'b0; le = 1'b0; id_ctrl = '0; id_valid = 1'b0;
    stall = 1'b0; flush = 1'b0; ex_kill = 1'b0;

    // Reset with clock running
    #3;
    chk_stages("rst", 14'h0, 14'h0, 14'h0, 3'b000);
    chk("rst cnt", 64'(bubble_cnt), 64'd0);
    chk("rst id_ready", 64'(id_ready), 64'd0);
    #9;
    R = 1'b1; le = 1'b1; id_ctrl = 14'h1A5; id_valid = 1'b1;

    // Streaming
    step();
    chk_stages("e1", 14'h1A5, 14'h000, 14'h000, 3'b001);
    id_ctrl = 14'h2C3;
    step();
    chk_stages("e2", 14'h2C3, 14'h0A1, 14'h000, 3'b011);
    id_ctrl = 14'h0F0;
    step();
    chk_stages("e3", 14'h0F0, 14'h0C3, 14'h020, 3'b111);
    chk("e3 cnt", 64'(bubble_cnt), 64'd0);

    // Stall two edges
    id_ctrl = 14'h3FF; stall = 1'b1;
    #1;
    chk("stall id_ready", 64'(id_ready), 64'd0);
    step();
    chk_stages("st1", 14'h000, 14'h0F0, 14'h000, 3'b110);
    chk("st1 cnt", 64'(bubble_cnt), 64'd1);
    step();
    chk_stages("st2", 14'h000, 14'h000, 14'h020, 3'b100);
    chk("st2 cnt", 64'(bubble_cnt), 64'd2);
    chk("st2 id_ready", 64'(id_ready), 64'd0);

    // Load 155, then flush+stall+ex_kill together
    stall = 1'b0; id_ctrl = 14'h155;
    #1;
    chk("run id_ready", 64'(id_ready), 64'd1);
    step();
    chk_stages("p155", 14'h155, 14'h000, 14'h000, 3'b001);
    stall = 1'b1; flush = 1'b1; ex_kill = 1'b1;
    step();
    chk_stages("fsk", 14'h000, 14'h000, 14'h000, 3'b000);
    chk("fsk cnt", 64'(bubble_cnt), 64'd3);

    // Flush alone with no valid instruction still counts
    stall = 1'b0; ex_kill = 1'b0; id_valid = 1'b0;
    step();
    chk("flush nv cnt", 64'(bubble_cnt), 64'd4);
    chk("flush nv v", 64'(stage_valid), 64'd0);

    // Refill, then freeze with stall asserted
    flush = 1'b0; id_valid = 1'b1; id_ctrl = 14'h2AB;
    step();
    id_ctrl = 14'h3C1;
    step();
    chk_stages("fill", 14'h3C1, 14'h0AB, 14'h000, 3'b011);
    le = 1'b0; stall = 1'b1; id_ctrl = 14'h111;
    #1;
    chk("frz id_ready", 64'(id_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_stages("frz", 14'h3C1, 14'h0AB, 14'h000, 3'b011);
      chk("frz cnt", 64'(bubble_cnt), 64'd4);
      id_ctrl = id_ctrl + 14'h111;
    end
    le = 1'b1; stall = 1'b0; id_valid = 1'b0;
    step();
    chk_stages("thaw", 14'h000, 14'h0C1, 14'h020, 3'b110);
    chk("thaw cnt", 64'(bubble_cnt), 64'd4);

    // Asynchronous reset between edges
    #2;
    R = 1'b0;
    #1;
    chk_stages("arst", 14'h0, 14'h0, 14'h0, 3'b000);
    chk("arst cnt", 64'(bubble_cnt), 64'd0);
    chk("arst small cnt", 64'(s_bubble_cnt), 64'd0);
    #1;
    R = 1'b1;

    // Saturation of the 3-bit counter
    stall = 1'b1; id_valid = 1'b1; id_ctrl = 14'h3FF;
    for (int i = 0; i < 6; i++) step();
    chk("sat6 small", 64'(s_bubble_cnt), 64'd6);
    for (int i = 0; i < 4; i++) step();
    chk("sat10 small", 64'(s_bubble_cnt), 64'd7);
    chk("sat10 main", 64'(bubble_cnt), 64'd10);
    chk("sat10 small v", 64'(s_stage_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
